// File: rtl/add_const_pipeline_bp.sv
// Multi-stage x + INCR pipeline with valid/ready on both sides, bubble-collapsing
// stall handling, synchronous flush and a registered occupancy count.
module add_const_pipeline_bp #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      STAGES   = 2,
    parameter logic [WIDTH-1:0] INCR     = WIDTH'(1),
    parameter bit               SATURATE = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             input_valid,
    output logic                             input_ready,
    input  logic [WIDTH-1:0]                 x,
    input  logic                             flush,
    output logic                             output_valid,
    input  logic                             output_ready,
    output logic [WIDTH-1:0]                 out,
    output logic [$clog2(STAGES+1)-1:0]      occupancy
);

    localparam int unsigned OW = $clog2(STAGES + 1);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [OW-1:0]     r_occ;

    logic [STAGES-1:0] w_en;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_valid_nxt;
    logic [WIDTH-1:0]  w_din [STAGES];
    logic [OW-1:0]     w_occ_nxt;
    logic              w_accept;

    // Sum at WIDTH+1 bits so the carry decides between wrap and clamp.
    function automatic logic [WIDTH-1:0] add_incr(input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sum;
        sum = {1'b0, d} + {1'b0, INCR};
        if (SATURATE && sum[WIDTH]) begin
            return {WIDTH{1'b1}};
        end else begin
            return sum[WIDTH-1:0];
        end
    endfunction

    // Stage enables: a stage may load when any stage from it downstream has a hole,
    // or the consumer is draining the last stage.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        w_en     = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_full = all_full & r_valid[i];
            w_en[i]  = ~all_full | output_ready;
        end
    end

    assign input_ready = w_en[0] & ~flush & rst;
    assign w_accept    = input_valid & input_ready;

    // Next-state valids, data load strobes and the data presented to each stage.
    always_comb begin
        w_valid_nxt = r_valid;
        w_load      = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_din[i] = '0;
        end
        w_din[0]  = x;
        w_load[0] = w_accept;
        if (w_en[0]) begin
            w_valid_nxt[0] = input_valid;
        end else begin
            w_valid_nxt[0] = r_valid[0];
        end
        for (int i = 1; i < STAGES; i++) begin
            // The increment is applied on the hop from stage 0 into stage 1.
            if (i == 1) begin
                w_din[i] = add_incr(r_data[0]);
            end else begin
                w_din[i] = r_data[i-1];
            end
            w_load[i] = w_en[i] & r_valid[i-1];
            if (w_en[i]) begin
                w_valid_nxt[i] = r_valid[i-1];
            end else begin
                w_valid_nxt[i] = r_valid[i];
            end
        end
        if (!rst || flush) begin
            w_valid_nxt = '0;
        end else begin
            w_valid_nxt = w_valid_nxt;
        end
    end

    // Popcount of the next-state valids feeds the registered occupancy.
    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ_nxt = w_occ_nxt + OW'(w_valid_nxt[i]);
        end
    end

    // Pipeline state; data registers only load when a valid item moves in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            for (int i = 0; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= w_din[i];
                end
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_single
            assign out = add_incr(r_data[0]);
        end else begin : g_multi
            assign out = r_data[STAGES-1];
        end
    endgenerate

    assign output_valid = r_valid[STAGES-1] & ~flush;
    assign occupancy    = r_occ;

endmodule

// File: tb/tb_add_const_pipeline_bp.sv
// Scoreboard bench: three configurations (2-stage wrap, 4-stage saturating +16,
// 1-stage saturating) driven with directed and random handshake traffic.
module tb_add_const_pipeline_bp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_iv, a_ir, a_fl, a_ov, a_or;
    logic [31:0] a_x, a_out;
    logic [1:0]  a_occ;
    logic        b_iv, b_ir, b_fl, b_ov, b_or;
    logic [31:0] b_x, b_out;
    logic [2:0]  b_occ;
    logic        c_iv, c_ir, c_fl, c_ov, c_or;
    logic [31:0] c_x, c_out;
    logic [0:0]  c_occ;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];

    add_const_pipeline_bp #(.WIDTH(32), .STAGES(2), .INCR(32'd1), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(rst), .input_valid(a_iv), .input_ready(a_ir), .x(a_x), .flush(a_fl),
        .output_valid(a_ov), .output_ready(a_or), .out(a_out), .occupancy(a_occ));

    add_const_pipeline_bp #(.WIDTH(32), .STAGES(4), .INCR(32'd16), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(rst), .input_valid(b_iv), .input_ready(b_ir), .x(b_x), .flush(b_fl),
        .output_valid(b_ov), .output_ready(b_or), .out(b_out), .occupancy(b_occ));

    add_const_pipeline_bp #(.WIDTH(32), .STAGES(1), .INCR(32'd1), .SATURATE(1'b1)) u_c (
        .clk(clk), .rst(rst), .input_valid(c_iv), .input_ready(c_ir), .x(c_x), .flush(c_fl),
        .output_valid(c_ov), .output_ready(c_or), .out(c_out), .occupancy(c_occ));

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] inc, input bit sat);
        logic [32:0] s;
        s = {1'b0, d} + {1'b0, inc};
        if (sat && s[32]) return 32'hFFFF_FFFF;
        return s[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accepted input, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            qa.delete();
            qb.delete();
            qc.delete();
        end else begin
            if (a_fl) qa.delete();
            if (b_fl) qb.delete();
            if (c_fl) qc.delete();
            if (a_ov && a_or) begin
                check_eq("a_q_nonempty", qa.size() != 0, 1'b1);
                if (qa.size() != 0) check_eq("a_out", a_out, qa.pop_front());
            end
            if (b_ov && b_or) begin
                check_eq("b_q_nonempty", qb.size() != 0, 1'b1);
                if (qb.size() != 0) check_eq("b_out", b_out, qb.pop_front());
            end
            if (c_ov && c_or) begin
                check_eq("c_q_nonempty", qc.size() != 0, 1'b1);
                if (qc.size() != 0) check_eq("c_out", c_out, qc.pop_front());
            end
            if (a_iv && a_ir) qa.push_back(model(a_x, 32'd1, 1'b0));
            if (b_iv && b_ir) qb.push_back(model(b_x, 32'd16, 1'b1));
            if (c_iv && c_ir) qc.push_back(model(c_x, 32'd1, 1'b1));
        end
    end

    logic [31:0] sv [4] = '{32'd0, 32'd1, 32'd2, 32'd5};
    logic [31:0] bv [4] = '{32'd10, 32'd20, 32'd30, 32'hFFFF_FFF0};

    initial begin
        rst  = 1'b0;
        a_iv = 1'b0; a_fl = 1'b0; a_or = 1'b0; a_x = 32'd0;
        b_iv = 1'b0; b_fl = 1'b0; b_or = 1'b0; b_x = 32'd0;
        c_iv = 1'b0; c_fl = 1'b0; c_or = 1'b0; c_x = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_ov", a_ov, 1'b0);
        check_eq("rst_a_out", a_out, 32'd0);
        check_eq("rst_a_occ", a_occ, 2'd0);
        check_eq("rst_a_ir", a_ir, 1'b0);
        check_eq("rst_b_occ", b_occ, 3'd0);
        check_eq("rst_c_out", c_out, 32'd1);
        check_eq("rst_c_ov", c_ov, 1'b0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("rel_a_ir", a_ir, 1'b1);
        check_eq("rel_b_ir", b_ir, 1'b1);
        check_eq("rel_c_ir", c_ir, 1'b1);

        // Streaming on the 2-stage wrap instance
        a_or = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) begin a_iv = 1'b1; a_x = sv[k]; end
            else a_iv = 1'b0;
            @(negedge clk);
            if (k == 1) check_eq("stream_a_ov_early", a_ov, 1'b0);
            if (k >= 2) begin
                check_eq("stream_a_occ", a_occ, 2'd2);
                check_eq("stream_a_ov", a_ov, 1'b1);
            end
        end
        tick(); a_iv = 1'b1; a_x = 32'hFFFF_FFFF;
        tick(); a_iv = 1'b0;
        repeat (4) tick();

        // Stall with full pipe on the 4-stage instance, then release
        b_or = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); b_iv = 1'b1; b_x = bv[k];
        end
        tick(); b_x = 32'd99;
        @(negedge clk);
        check_eq("stall_b_ir", b_ir, 1'b0);
        check_eq("stall_b_occ", b_occ, 3'd4);
        check_eq("stall_b_ov", b_ov, 1'b1);
        check_eq("stall_b_out", b_out, 32'd26);
        tick();
        @(negedge clk);
        check_eq("stall_b_hold", b_out, 32'd26);
        check_eq("stall_b_occ_hold", b_occ, 3'd4);
        tick(); b_or = 1'b1;
        @(negedge clk);
        check_eq("release_b_ir", b_ir, 1'b1);
        tick(); b_iv = 1'b0;
        repeat (8) tick();

        // Flush with three items in flight and a simultaneous input
        b_or = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(); b_iv = 1'b1; b_x = 32'(k);
        end
        tick(); b_x = 32'd555; b_fl = 1'b1; b_or = 1'b1;
        @(negedge clk);
        check_eq("flush_b_occ_before", b_occ, 3'd3);
        check_eq("flush_b_ov", b_ov, 1'b0);
        check_eq("flush_b_ir", b_ir, 1'b0);
        tick(); b_fl = 1'b0; b_iv = 1'b0;
        @(negedge clk);
        check_eq("flush_b_occ_after", b_occ, 3'd0);
        check_eq("flush_b_ov_after", b_ov, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("flush_b_quiet", b_ov, 1'b0);
        end
        tick(); b_iv = 1'b1; b_x = 32'd4;
        tick(); b_iv = 1'b0;
        repeat (6) tick();

        // Degenerate single-stage depth
        c_or = 1'b0;
        tick(); c_iv = 1'b1; c_x = 32'd7;
        tick(); c_iv = 1'b0;
        @(negedge clk);
        check_eq("deg_c_ov", c_ov, 1'b1);
        check_eq("deg_c_out", c_out, 32'd8);
        check_eq("deg_c_ir", c_ir, 1'b0);
        tick();
        @(negedge clk);
        check_eq("deg_c_hold", c_out, 32'd8);
        tick(); c_or = 1'b1;
        tick(); c_iv = 1'b1; c_x = 32'hFFFF_FFFF;
        tick(); c_iv = 1'b0;
        repeat (3) tick();

        // Reset mid-stream with a full 2-stage pipe
        a_or = 1'b0;
        tick(); a_iv = 1'b1; a_x = 32'd40;
        tick(); a_x = 32'd41;
        tick(); a_x = 32'd42; rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_a_ir", a_ir, 1'b0);
        tick(); rst = 1'b1; a_iv = 1'b0; a_or = 1'b1;
        @(negedge clk);
        check_eq("midrst_a_ov", a_ov, 1'b0);
        check_eq("midrst_a_out", a_out, 32'd0);
        check_eq("midrst_a_occ", a_occ, 2'd0);
        check_eq("midrst_a_ir_rel", a_ir, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("midrst_a_quiet", a_ov, 1'b0);
        end

        // Random traffic and backpressure on all three
        for (int k = 0; k < 400; k++) begin
            tick();
            a_iv = 1'($urandom_range(0, 1)); a_x = $urandom; a_or = 1'($urandom_range(0, 1));
            b_iv = 1'($urandom_range(0, 1)); b_or = 1'($urandom_range(0, 1));
            b_x  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 40))) : $urandom;
            c_iv = 1'($urandom_range(0, 1)); c_x = $urandom; c_or = 1'($urandom_range(0, 1));
        end
        tick();
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check_eq("drain_qa", qa.size(), 0);
        check_eq("drain_qb", qb.size(), 0);
        check_eq("drain_qc", qc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
